// File: rtl/bullet_engine.sv
// Projectile pool: spawns bullets on fire, advances one slot per cycle on each movement tick,
// and reports wall collisions to the map block as single-cycle hit pulses.
module bullet_engine #(
  parameter int unsigned NUM_BULLETS = 4,
  parameter int unsigned MAP_W       = 64,
  parameter int unsigned MAP_H       = 44
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 i_top_state,
  input  logic [MAP_W*MAP_H-1:0]     i_map,
  input  logic                       i_tick,
  input  logic                       i_fire_valid,
  input  logic [5:0]                 i_fire_x,
  input  logic [5:0]                 i_fire_y,
  input  logic [1:0]                 i_fire_dir,
  output logic                       o_fire_ready,
  output logic                       o_hit_valid,
  output logic [5:0]                 o_hit_x,
  output logic [5:0]                 o_hit_y,
  output logic [NUM_BULLETS-1:0]     o_bullet_valid,
  output logic [6*NUM_BULLETS-1:0]   o_bullet_x,
  output logic [6*NUM_BULLETS-1:0]   o_bullet_y
);

  localparam int unsigned     IdxW    = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
  localparam int unsigned     MapIdxW = $clog2(MAP_W * MAP_H);
  localparam logic [5:0]      XMax    = 6'(MAP_W - 1);
  localparam logic [5:0]      YMax    = 6'(MAP_H - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_BULLETS - 1);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic                   tick_pending_q, tick_pending_d;
  logic [NUM_BULLETS-1:0] valid_q;
  logic [5:0]             x_q   [NUM_BULLETS];
  logic [5:0]             y_q   [NUM_BULLETS];
  logic [1:0]             dir_q [NUM_BULLETS];
  logic                   hit_valid_q;
  logic [5:0]             hit_x_q, hit_y_q;

  logic                   play;
  logic                   any_free;
  logic [IdxW-1:0]        free_idx;
  logic                   fire_accept;
  logic                   spawn_in_map;
  logic [5:0]             cur_x, cur_y, nx, ny;
  logic [1:0]             cur_dir;
  logic                   oob, wall, scan_act;
  logic [MapIdxW-1:0]     map_idx;

  assign play         = (i_top_state == 2'b01);
  assign fire_accept  = o_fire_ready && i_fire_valid;
  assign spawn_in_map = (i_fire_x <= XMax) && (i_fire_y <= YMax);

  // Lowest-index free slot wins.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        any_free = 1'b1;
        free_idx = IdxW'(i);
      end
    end
  end

  // Bounds are tested before stepping so coordinates never wrap.
  always_comb begin
    cur_x   = x_q[idx_q];
    cur_y   = y_q[idx_q];
    cur_dir = dir_q[idx_q];
    nx      = cur_x;
    ny      = cur_y;
    oob     = 1'b0;
    unique case (cur_dir)
      2'd0: if (cur_y == 6'd0) oob = 1'b1; else ny = cur_y - 6'd1;
      2'd1: if (cur_x == XMax) oob = 1'b1; else nx = cur_x + 6'd1;
      2'd2: if (cur_y == YMax) oob = 1'b1; else ny = cur_y + 6'd1;
      2'd3: if (cur_x == 6'd0) oob = 1'b1; else nx = cur_x - 6'd1;
      default: oob = 1'b1;
    endcase
    map_idx  = MapIdxW'(ny) * MapIdxW'(MAP_W) + MapIdxW'(MAP_W - 1) - MapIdxW'(nx);
    wall     = !oob && i_map[map_idx];
    scan_act = play && (state_q == StScan) && valid_q[idx_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      tick_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      tick_pending_q <= tick_pending_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    tick_pending_d = tick_pending_q;
    if (!play) begin
      state_d        = StIdle;
      idx_d          = '0;
      tick_pending_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_tick || tick_pending_q) begin
            state_d        = StScan;
            idx_d          = '0;
            tick_pending_d = 1'b0;
          end
        end
        StScan: begin
          if (i_tick) tick_pending_d = 1'b1;
          if (idx_q == LastIdx) begin
            state_d = StIdle;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    o_fire_ready = play && (state_q == StIdle) && any_free;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      hit_valid_q <= 1'b0;
      hit_x_q     <= '0;
      hit_y_q     <= '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        x_q[i]   <= '0;
        y_q[i]   <= '0;
        dir_q[i] <= '0;
      end
    end else begin
      hit_valid_q <= 1'b0;
      if (!play) begin
        valid_q <= '0;
      end else begin
        if (scan_act) begin
          if (oob) begin
            valid_q[idx_q] <= 1'b0;
          end else if (wall) begin
            valid_q[idx_q] <= 1'b0;
            hit_valid_q    <= 1'b1;
            hit_x_q        <= nx;
            hit_y_q        <= ny;
          end else begin
            x_q[idx_q] <= nx;
            y_q[idx_q] <= ny;
          end
        end
        // Fire is only accepted in idle, so it never collides with a scan update.
        if (fire_accept && spawn_in_map) begin
          valid_q[free_idx] <= 1'b1;
          x_q[free_idx]     <= i_fire_x;
          y_q[free_idx]     <= i_fire_y;
          dir_q[free_idx]   <= i_fire_dir;
        end
      end
    end
  end

  always_comb begin
    o_hit_valid    = hit_valid_q;
    o_hit_x        = hit_x_q;
    o_hit_y        = hit_y_q;
    o_bullet_valid = valid_q;
    o_bullet_x     = '0;
    o_bullet_y     = '0;
    for (int k = 0; k < NUM_BULLETS; k++) begin
      o_bullet_x[6*k +: 6] = x_q[k];
      o_bullet_y[6*k +: 6] = y_q[k];
    end
  end

endmodule

// File: tb/tb_bullet_engine.sv
// Directed bench for bullet_engine; hit pulses are checked by a scoreboard monitor.
module tb_bullet_engine;

  localparam int NB    = 4;
  localparam int MAP_W = 64;
  localparam int MAP_H = 44;

  logic                   clk;
  logic                   rst_n;
  logic [1:0]             i_top_state;
  logic [MAP_W*MAP_H-1:0] i_map;
  logic                   i_tick;
  logic                   i_fire_valid;
  logic [5:0]             i_fire_x, i_fire_y;
  logic [1:0]             i_fire_dir;
  logic                   o_fire_ready;
  logic                   o_hit_valid;
  logic [5:0]             o_hit_x, o_hit_y;
  logic [NB-1:0]          o_bullet_valid;
  logic [6*NB-1:0]        o_bullet_x, o_bullet_y;

  int vectors     = 0;
  int miscompares = 0;
  logic [11:0] exp_q[$];

  bullet_engine #(.NUM_BULLETS(NB), .MAP_W(MAP_W), .MAP_H(MAP_H)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_top_state    (i_top_state),
    .i_map          (i_map),
    .i_tick         (i_tick),
    .i_fire_valid   (i_fire_valid),
    .i_fire_x       (i_fire_x),
    .i_fire_y       (i_fire_y),
    .i_fire_dir     (i_fire_dir),
    .o_fire_ready   (o_fire_ready),
    .o_hit_valid    (o_hit_valid),
    .o_hit_x        (o_hit_x),
    .o_hit_y        (o_hit_y),
    .o_bullet_valid (o_bullet_valid),
    .o_bullet_x     (o_bullet_x),
    .o_bullet_y     (o_bullet_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every hit pulse must match the oldest expected hit.
  always @(negedge clk) begin
    if (rst_n && o_hit_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL hit_unexpected: got (%0d,%0d), expected no hit", o_hit_x, o_hit_y);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if ({o_hit_x, o_hit_y} !== e) begin
          miscompares++;
          $display("FAIL hit_cell: got (%0d,%0d), expected (%0d,%0d)",
                   o_hit_x, o_hit_y, e[11:6], e[5:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_wall(input int x, input int y);
    i_map[y*MAP_W + (MAP_W-1-x)] = 1'b1;
  endtask

  task automatic fire(input logic [5:0] x, input logic [5:0] y, input logic [1:0] d);
    i_fire_valid = 1'b1;
    i_fire_x     = x;
    i_fire_y     = y;
    i_fire_dir   = d;
    check("fire_ready", 32'(o_fire_ready), 32'd1);
    cyc(1);
    i_fire_valid = 1'b0;
  endtask

  // One tick from idle, then wait out the full scan.
  task automatic tick_scan();
    i_tick = 1'b1;
    cyc(1);
    i_tick = 1'b0;
    cyc(NB);
  endtask

  function automatic logic [5:0] bx(input int k);
    return o_bullet_x[6*k +: 6];
  endfunction

  function automatic logic [5:0] by(input int k);
    return o_bullet_y[6*k +: 6];
  endfunction

  initial begin
    rst_n        = 1'b0;
    i_top_state  = 2'b00;
    i_map        = '0;
    i_tick       = 1'b0;
    i_fire_valid = 1'b0;
    i_fire_x     = '0;
    i_fire_y     = '0;
    i_fire_dir   = '0;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);

    // Reset state while not playing.
    check("rst_hit_valid", 32'(o_hit_valid), 32'd0);
    check("rst_hit_xy", 32'({o_hit_x, o_hit_y}), 32'd0);
    check("rst_bullet_valid", 32'(o_bullet_valid), 32'd0);
    check("rst_bullet_x", 32'(o_bullet_x), 32'd0);
    check("rst_fire_ready", 32'(o_fire_ready), 32'd0);
    i_top_state = 2'b01;
    cyc(1);
    check("play_fire_ready", 32'(o_fire_ready), 32'd1);

    // Plain move right on an empty map; off-map spawn is swallowed.
    fire(6'd10, 6'd5, 2'd1);
    check("spawn_valid", 32'(o_bullet_valid), 32'b0001);
    fire(6'd5, 6'd50, 2'd0);
    check("offmap_spawn", 32'(o_bullet_valid), 32'b0001);
    tick_scan();
    check("move_x", 32'(bx(0)), 32'd11);
    check("move_y", 32'(by(0)), 32'd5);
    check("move_valid", 32'(o_bullet_valid), 32'b0001);

    // Wall directly ahead: one hit, slot freed, position frozen.
    set_wall(12, 5);
    exp_q.push_back({6'd12, 6'd5});
    tick_scan();
    check("wall_valid", 32'(o_bullet_valid), 32'b0000);
    check("wall_x_frozen", 32'(bx(0)), 32'd11);

    // Map edges: freed without a hit.
    fire(6'd63, 6'd0, 2'd1);
    fire(6'd0, 6'd43, 2'd2);
    check("edge_spawn", 32'(o_bullet_valid), 32'b0011);
    tick_scan();
    check("edge_freed", 32'(o_bullet_valid), 32'b0000);

    // Fill the pool, then a double tick during a scan yields exactly one extra scan.
    fire(6'd30, 6'd30, 2'd0);
    fire(6'd31, 6'd30, 2'd0);
    fire(6'd32, 6'd30, 2'd0);
    fire(6'd33, 6'd30, 2'd0);
    check("full_ready", 32'(o_fire_ready), 32'd0);
    i_fire_valid = 1'b1;
    i_fire_x     = 6'd40;
    i_fire_y     = 6'd40;
    cyc(1);
    i_fire_valid = 1'b0;
    check("full_valid", 32'(o_bullet_valid), 32'b1111);
    check("full_slot3_x", 32'(bx(3)), 32'd33);
    i_tick = 1'b1;
    cyc(1);
    cyc(2);
    i_tick = 1'b0;
    cyc(12);
    check("double_tick_y0", 32'(by(0)), 32'd28);
    check("double_tick_y3", 32'(by(3)), 32'd28);

    // Leaving play clears the pool; ticks ignored meanwhile.
    i_top_state = 2'b00;
    i_tick      = 1'b1;
    cyc(1);
    check("stop_valid", 32'(o_bullet_valid), 32'b0000);
    check("stop_ready", 32'(o_fire_ready), 32'd0);
    cyc(2);
    i_tick      = 1'b0;
    i_top_state = 2'b01;
    cyc(1);

    // Two bullets hitting the same cell in one scan: two pulses.
    set_wall(20, 10);
    fire(6'd19, 6'd10, 2'd1);
    fire(6'd5, 6'd40, 2'd1);
    fire(6'd21, 6'd10, 2'd3);
    exp_q.push_back({6'd20, 6'd10});
    exp_q.push_back({6'd20, 6'd10});
    tick_scan();
    check("dual_hit_valid", 32'(o_bullet_valid), 32'b0010);
    check("dual_hit_slot1_x", 32'(bx(1)), 32'd6);

    // Leave play mid-scan after the first hit: the second hit must not appear.
    fire(6'd19, 6'd10, 2'd1);
    fire(6'd20, 6'd9, 2'd2);
    check("mid_spawn", 32'(o_bullet_valid), 32'b0111);
    exp_q.push_back({6'd20, 6'd10});
    i_tick = 1'b1;
    cyc(1);
    i_tick = 1'b0;
    cyc(1);
    check("mid_first_hit", 32'(o_hit_valid), 32'd1);
    i_top_state = 2'b10;
    cyc(1);
    check("mid_stop_valid", 32'(o_bullet_valid), 32'b0000);
    check("mid_stop_hit", 32'(o_hit_valid), 32'd0);
    cyc(6);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bullet_engine.md
Name: bullet_engine

Overview:
- Projectile engine: the initiator side of the wall-hit interface and the reader of the 64x44 wall bitmap.
- Holds a small pool of bullets and advances each one cell per movement tick.
- On each move, tests the destination cell against the map. A wall collision emits a single-cycle hit (x, y) to the map block and frees the bullet.
- Bullet positions are exported to the renderer.

Parameters:
NUM_BULLETS, 4, bullet pool size (1..8)
MAP_W, 64, map width in cells (x range 0..MAP_W-1)
MAP_H, 44, map height in cells (y range 0..MAP_H-1)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
i_top_state  input  2  game state; 2'b01 = play, all other values = not playing
i_map  input  MAP_W*MAP_H  wall bitmap; cell (x,y) is bit y*64+(63-x), 1 = wall present
i_tick  input  1  movement strobe, one cycle wide
i_fire_valid  input  1  fire request
i_fire_x  input  6  spawn x
i_fire_y  input  6  spawn y
i_fire_dir  input  2  direction: 0 up (y-1), 1 right (x+1), 2 down (y+1), 3 left (x-1)
o_fire_ready  output  1  fire request accepted this cycle when high together with i_fire_valid
o_hit_valid  output  1  one-cycle hit pulse toward the map block
o_hit_x  output  6  hit cell x
o_hit_y  output  6  hit cell y
o_bullet_valid  output  NUM_BULLETS  slot occupied
o_bullet_x  output  6*NUM_BULLETS  slot k x at bits [6k+5:6k]
o_bullet_y  output  6*NUM_BULLETS  slot k y at bits [6k+5:6k]

Behaviour:
- Reset values:
  - all slots invalid; positions and directions 0
  - FSM = IDLE; tick_pending = 0; scan index = 0
  - o_hit_valid/x/y = 0; o_fire_ready = 0
- All outputs are registered except o_fire_ready, which is combinational.
- FSM states: IDLE, SCAN.
- IDLE:
  - If i_tick or tick_pending is set, go to SCAN with index = 0 and clear tick_pending.
- SCAN:
  - Processes exactly one slot per cycle (slot = index).
  - After slot NUM_BULLETS-1, return to IDLE.
  - A scan therefore lasts exactly NUM_BULLETS cycles.
- Per-slot processing, valid slot:
  - Compute the next cell from the stored direction.
  - Out of bounds (x=0 moving left, x=MAP_W-1 moving right, y=0 moving up, y=MAP_H-1 moving down): slot freed, no hit.
  - Next cell is a wall in i_map (sampled in this SCAN cycle): slot freed; next cycle o_hit_valid=1 with o_hit_x/y = wall cell; position is not updated.
  - Otherwise: position <- next cell.
- Per-slot processing, invalid slot: no action, cycle still consumed.
- Hit output:
  - o_hit_valid is high for exactly one cycle per collision.
  - At most one hit per cycle; consecutive hits are possible on consecutive cycles.
  - Two bullets hitting the same cell in one scan produce two separate pulses.
  - The engine does not wait for the map to update.
- Tick during SCAN: sets tick_pending. Further ticks while tick_pending=1 are dropped (one-deep).
- Fire:
  - o_fire_ready = (i_top_state==2'b01) && FSM==IDLE && at least one slot is free.
  - On accept, the lowest-index free slot loads x, y, dir and becomes valid the next cycle.
  - The spawn cell is not wall-checked; the first check happens on the first move.
  - Fire and tick in the same IDLE cycle: both take effect, and the new bullet is moved in that scan.
  - Spawn coordinates outside the map (x>=MAP_W or y>=MAP_H): request is accepted and discarded, no slot used.
- Leaving play (i_top_state != 2'b01), including mid-scan:
  - Next cycle: all slots invalid, FSM=IDLE, tick_pending=0, o_hit_valid=0.
  - Any collision computed in that same cycle is suppressed.
  - Ticks and fires are ignored while not playing.
- Widths: coordinates are 6-bit unsigned. Bounds are checked before any add/subtract, so wrap-around never occurs.

Test Plan:
- Reset, then i_top_state=00 -> all outputs 0, o_fire_ready=0. Set state 01 -> o_fire_ready=1 next cycle.
- Empty map; fire (10,5) dir 1; one tick -> after NUM_BULLETS+1 cycles slot0 at (11,5) valid; o_hit_valid never asserted.
- Wall at (12,5); bullet at (11,5) dir 1; tick -> o_hit_valid pulses once with (12,5); slot0 invalid; bullet position stays (11,5) until cleared.
- Bullets at (63,0) dir 1 and (0,43) dir 2 (down at y=43); tick -> both freed, no hit pulse.
- Fire 4 bullets (NUM_BULLETS=4) -> o_fire_ready low after 4th accept; 5th request ignored. Tick asserted twice during a scan -> exactly one extra scan runs.
- Bullets in slots 0 and 2 both adjacent to wall (20,10); tick -> two o_hit_valid pulses with (20,10). Switch state to 10 mid-scan -> all slots cleared next cycle, no further hits.
